// File: rtl/capture_controller_pkg.sv
// Shared capture definitions: state encodings and default widths.
// The step limiter reuses CAP_COUNT_WIDTH for its limit port.
package capture_defs;

  localparam int CAP_PROBE_WIDTH = 8;
  localparam int CAP_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_RUNNING = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_e;

  // A new capture may only be armed from a quiescent state.
  function automatic logic can_arm(input cap_state_e st);
    return (st == CAP_IDLE) || (st == CAP_DONE);
  endfunction

endpackage

// File: rtl/capture_controller_if.sv
// Host/limiter-facing bundle of the capture controller; slave is the controller side.
// All slave outputs are driven from registered state, so there is no input-to-output path.
interface capture_controller_if
  import capture_defs::*;
#(
  parameter int PROBE_WIDTH = CAP_PROBE_WIDTH,
  parameter int COUNT_WIDTH = CAP_COUNT_WIDTH
);

  logic                   start;
  logic                   abort;
  logic                   edge_mode;
  logic [PROBE_WIDTH-1:0] trig_mask;
  logic [PROBE_WIDTH-1:0] trig_value;
  logic [PROBE_WIDTH-1:0] probe;
  logic                   stop;
  logic                   run;
  logic                   armed;
  logic                   done;
  logic                   aborted;
  logic [COUNT_WIDTH-1:0] sample_count;

  modport master (
    output start, abort, edge_mode, trig_mask, trig_value, probe, stop,
    input  run, armed, done, aborted, sample_count
  );

  modport slave (
    input  start, abort, edge_mode, trig_mask, trig_value, probe, stop,
    output run, armed, done, aborted, sample_count
  );

endinterface

// File: rtl/capture_controller_trigger_matcher.sv
// Probe pipeline plus latched mask/value/mode; trig is combinational from flops only.
// probe_q feeds the match, probe_qq feeds the previous-match used for rising detection.
module trigger_matcher
  import capture_defs::*;
#(
  parameter int PROBE_WIDTH = CAP_PROBE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   edge_mode,
  input  logic [PROBE_WIDTH-1:0] trig_mask,
  input  logic [PROBE_WIDTH-1:0] trig_value,
  input  logic [PROBE_WIDTH-1:0] probe,
  output logic                   trig
);

  logic [PROBE_WIDTH-1:0] probe_q, probe_d;
  logic [PROBE_WIDTH-1:0] probe_qq, probe_qq_d;
  logic [PROBE_WIDTH-1:0] mask_q, mask_d;
  logic [PROBE_WIDTH-1:0] value_q, value_d;
  logic                   mode_q, mode_d;
  logic                   first_q, first_d;
  logic                   match;
  logic                   match_prev;

  always_comb begin
    probe_d    = probe;
    probe_qq_d = probe_q;
    mask_d     = mask_q;
    value_d    = value_q;
    mode_d     = mode_q;
    first_d    = load;
    if (load) begin
      mask_d  = trig_mask;
      value_d = trig_value;
      mode_d  = edge_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      probe_q  <= '0;
      probe_qq <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      mode_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      probe_q  <= probe_d;
      probe_qq <= probe_qq_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      mode_q   <= mode_d;
      first_q  <= first_d;
    end
  end

  // probe_qq predates the arm on the first armed cycle, so edge mode ignores it there.
  always_comb begin
    match      = ((probe_q  ^ value_q) & mask_q) == '0;
    match_prev = ((probe_qq ^ value_q) & mask_q) == '0;
    trig       = mode_q ? (match & ~match_prev & ~first_q) : match;
  end

endmodule

// File: rtl/capture_controller.sv
// Capture run sequencer: arm on start, raise run on trigger, end on stop or abort.
// Probe-to-run latency 2 cycles; stop/abort take effect on the sampling edge.
module capture_controller
  import capture_defs::*;
#(
  parameter int PROBE_WIDTH = CAP_PROBE_WIDTH,
  parameter int COUNT_WIDTH = CAP_COUNT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  capture_controller_if.slave bus
);

  cap_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   aborted_q, aborted_d;
  logic                   load;
  logic                   trig;

  assign load = can_arm(state_q) && bus.start && !bus.abort;

  trigger_matcher #(
    .PROBE_WIDTH (PROBE_WIDTH)
  ) u_matcher (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .edge_mode  (bus.edge_mode),
    .trig_mask  (bus.trig_mask),
    .trig_value (bus.trig_value),
    .probe      (bus.probe),
    .trig       (trig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CAP_IDLE;
      count_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = CAP_IDLE;
    end else begin
      unique case (state_q)
        CAP_IDLE,
        CAP_DONE:    if (bus.start) state_d = CAP_ARMED;
        CAP_ARMED:   if (trig)      state_d = CAP_RUNNING;
        CAP_RUNNING: if (bus.stop)  state_d = CAP_DONE;
        default:                    state_d = CAP_IDLE;
      endcase
    end
  end

  // Abort freezes the count, including on an edge where run is still high.
  always_comb begin
    count_d   = count_q;
    aborted_d = aborted_q;
    if (bus.abort) begin
      if (state_q == CAP_ARMED || state_q == CAP_RUNNING) aborted_d = 1'b1;
    end else if (load) begin
      count_d   = '0;
      aborted_d = 1'b0;
    end else if (state_q == CAP_RUNNING && count_q != {COUNT_WIDTH{1'b1}}) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    bus.run          = (state_q == CAP_RUNNING);
    bus.armed        = (state_q == CAP_ARMED);
    bus.done         = (state_q == CAP_DONE);
    bus.aborted      = aborted_q;
    bus.sample_count = count_q;
  end

endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller; a 4-bit-counter twin shares the stimulus for saturation.
module tb_capture_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   run_seen;

  string       tag_q[$];
  logic [31:0] val_q[$];

  always #5 clk = ~clk;

  capture_controller_if #(.PROBE_WIDTH(8), .COUNT_WIDTH(32)) if32 ();
  capture_controller_if #(.PROBE_WIDTH(8), .COUNT_WIDTH(4))  if4 ();

  assign if4.start      = if32.start;
  assign if4.abort      = if32.abort;
  assign if4.edge_mode  = if32.edge_mode;
  assign if4.trig_mask  = if32.trig_mask;
  assign if4.trig_value = if32.trig_value;
  assign if4.probe      = if32.probe;
  assign if4.stop       = if32.stop;

  capture_controller #(.PROBE_WIDTH(8), .COUNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if32.slave)
  );

  capture_controller #(.PROBE_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    total++;
    if (val_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_underflow observed=%0h expected=<none>", obs);
      return;
    end
    tag = tag_q.pop_front();
    e   = val_q.pop_front();
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // Expect the full visible status of the 32-bit instance after the next edge(s).
  task automatic exp_status(input string tag, input logic r, input logic a,
                            input logic d, input logic ab, input logic [31:0] cnt);
    exp_push({tag, "_run"}, {31'd0, r});
    exp_push({tag, "_armed"}, {31'd0, a});
    exp_push({tag, "_done"}, {31'd0, d});
    exp_push({tag, "_aborted"}, {31'd0, ab});
    exp_push({tag, "_count"}, cnt);
  endtask

  task automatic chk_status();
    chk({31'd0, if32.run});
    chk({31'd0, if32.armed});
    chk({31'd0, if32.done});
    chk({31'd0, if32.aborted});
    chk(if32.sample_count);
  endtask

  task automatic exp_run(input string tag, input logic r);
    exp_push(tag, {31'd0, r});
  endtask

  initial begin
    if32.start      = 1'b0;
    if32.abort      = 1'b0;
    if32.edge_mode  = 1'b0;
    if32.trig_mask  = 8'h00;
    if32.trig_value = 8'h00;
    if32.probe      = 8'h00;
    if32.stop       = 1'b0;

    // Reset state
    exp_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(2);
    chk_status();
    rst = 1'b0;

    // Stop in IDLE is ignored
    if32.stop = 1'b1;
    exp_status("idle_stop", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.stop = 1'b0;

    // Level trigger: mask 0F, value 05, probe A5
    if32.trig_mask  = 8'h0F;
    if32.trig_value = 8'h05;
    if32.edge_mode  = 1'b0;
    if32.start      = 1'b1;
    exp_status("lvl_arm", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.start = 1'b0;
    step(3);
    exp_run("lvl_no_match_run", 1'b0);
    chk({31'd0, if32.run});
    if32.probe = 8'hA5;
    exp_run("lvl_lat1_run", 1'b0);
    step();
    chk({31'd0, if32.run});
    exp_run("lvl_lat2_run", 1'b1);
    step();
    chk({31'd0, if32.run});
    step(4);
    if32.stop = 1'b1;
    exp_status("lvl_stop", 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    step();
    chk_status();
    // Stop in DONE is ignored
    exp_status("done_stop", 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
    step();
    chk_status();
    if32.stop = 1'b0;

    // Edge mode, bit0 already high when armed
    if32.trig_mask  = 8'h01;
    if32.trig_value = 8'h01;
    if32.edge_mode  = 1'b1;
    if32.probe      = 8'h01;
    if32.start      = 1'b1;
    exp_status("edge_arm", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.start = 1'b0;
    step(2);
    if32.stop = 1'b1;
    exp_status("armed_stop", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.stop = 1'b0;
    step(3);
    exp_run("edge_held_run", 1'b0);
    chk({31'd0, if32.run});
    if32.probe = 8'h00;
    step(2);
    if32.probe = 8'h01;
    exp_run("edge_lat1_run", 1'b0);
    step();
    chk({31'd0, if32.run});
    exp_run("edge_lat2_run", 1'b1);
    step();
    chk({31'd0, if32.run});
    if32.stop = 1'b1;
    exp_status("edge_stop", 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
    step();
    chk_status();
    if32.stop = 1'b0;

    // Mask 0, level mode: run on the cycle after armed
    if32.trig_mask = 8'h00;
    if32.edge_mode = 1'b0;
    if32.start     = 1'b1;
    exp_status("m0lvl_arm", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.start = 1'b0;
    exp_run("m0lvl_run", 1'b1);
    step();
    chk({31'd0, if32.run});
    if32.stop = 1'b1;
    exp_status("m0lvl_stop", 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
    step();
    chk_status();
    if32.stop = 1'b0;

    // Mask 0, edge mode: never triggers
    if32.edge_mode = 1'b1;
    if32.start     = 1'b1;
    step();
    if32.start = 1'b0;
    run_seen = 0;
    for (int i = 0; i < 100; i++) begin
      if32.probe = 8'($urandom_range(0, 255));
      step();
      if (if32.run) run_seen++;
    end
    exp_push("m0edge_run_cycles", 32'd0);
    chk(32'(run_seen));
    // Abort from ARMED
    if32.abort = 1'b1;
    exp_status("armed_abort", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    step();
    chk_status();
    if32.abort = 1'b0;

    // Abort and stop together in RUNNING: abort wins, count held
    if32.edge_mode = 1'b0;
    if32.start     = 1'b1;
    exp_status("ab_arm", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.start = 1'b0;
    step(4);
    if32.abort = 1'b1;
    if32.stop  = 1'b1;
    exp_status("run_abort", 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
    step();
    chk_status();
    if32.abort = 1'b0;
    if32.stop  = 1'b0;
    exp_status("post_abort", 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
    step();
    chk_status();

    // Re-arm clears aborted and count, then run without stop into saturation
    if32.start = 1'b1;
    exp_status("rearm", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    if32.start = 1'b0;
    step(21);
    exp_status("sat32", 1'b1, 1'b0, 1'b0, 1'b0, 32'd20);
    chk_status();
    exp_push("sat4_count", 32'd15);
    chk({28'd0, if4.sample_count});
    exp_run("sat4_run", 1'b1);
    chk({31'd0, if4.run});

    // Reset mid-RUNNING clears everything with no done/aborted
    rst = 1'b1;
    exp_status("run_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();
    exp_push("run_rst_cnt4", 32'd0);
    chk({28'd0, if4.sample_count});
    rst = 1'b0;
    exp_status("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk_status();

    total++;
    assert (val_q.size() === 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", val_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
